// File: rtl/park_timer_bank_if.sv
// Command and status bundle for the parking-bay timer bank.
// The master drives the per-channel commands; the slave returns the registered channel status.
interface park_timer_bank_if #(
    parameter int CH    = 4,
    parameter int WIDTH = 10
);
    logic [CH-1:0]       start;
    logic [CH-1:0]       stop;
    logic [CH-1:0]       clear;
    logic [CH*WIDTH-1:0] count;
    logic [CH-1:0]       running;
    logic [CH-1:0]       expired;
    logic [CH-1:0]       wrap_pulse;

    modport master (
        output start, stop, clear,
        input  count, running, expired, wrap_pulse
    );

    modport slave (
        input  start, stop, clear,
        output count, running, expired, wrap_pulse
    );
endinterface

// File: rtl/park_timer_bank.sv
// Bank of CH independent bay timers sharing a prescaled tick; one IDLE/RUN/PAUSED FSM per bay.
// Commands take effect on the next edge and every output is a flop; there is no backpressure.
module park_timer_bank #(
    parameter int CH        = 4,
    parameter int WIDTH     = 10,
    parameter int MAX_COUNT = 999,
    parameter int TIMEOUT   = 900,
    parameter int PRESCALE  = 1,
    parameter int WRAP      = 1
) (
    input logic              clk,
    input logic              reset,
    park_timer_bank_if.slave bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

    logic [PW-1:0]    pre_q;
    logic             tick;

    state_t           state_q [CH];
    state_t           state_d [CH];
    logic [WIDTH-1:0] cnt_q   [CH];
    logic [WIDTH-1:0] cnt_d   [CH];
    logic [CH-1:0]    exp_q, exp_d;
    logic [CH-1:0]    wrap_q, wrap_d;
    logic [CH-1:0]    run_q, run_d;
    logic [CH-1:0]    adv;

    assign tick = (pre_q == PW'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= tick ? '0 : pre_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            exp_q  <= '0;
            wrap_q <= '0;
            run_q  <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            exp_q  <= exp_d;
            wrap_q <= wrap_d;
            run_q  <= run_d;
        end
    end

    always_comb begin
        adv    = '0;
        exp_d  = exp_q;
        wrap_d = '0;
        run_d  = '0;
        for (int i = 0; i < CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];

            // Priority clear > start > stop. A start while already running is a no-op,
            // but an asserted stop still blocks that cycle's increment.
            if (bus.clear[i]) begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
                exp_d[i]   = 1'b0;
            end else if (bus.start[i]) begin
                case (state_q[i])
                    IDLE: begin
                        state_d[i] = RUN;
                        cnt_d[i]   = '0;
                        exp_d[i]   = 1'b0;
                    end
                    PAUSED:  state_d[i] = RUN;
                    default: adv[i] = tick & ~bus.stop[i];
                endcase
            end else if (bus.stop[i]) begin
                if (state_q[i] == RUN) begin
                    state_d[i] = PAUSED;
                end
            end else begin
                adv[i] = tick && (state_q[i] == RUN);
            end

            if (adv[i] && !(cnt_q[i] == WIDTH'(MAX_COUNT) && WRAP == 0)) begin
                if (cnt_q[i] == WIDTH'(MAX_COUNT)) begin
                    cnt_d[i]  = '0;
                    wrap_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + WIDTH'(1);
                end
                if (cnt_d[i] == WIDTH'(TIMEOUT)) begin
                    exp_d[i] = 1'b1;
                end
            end

            run_d[i] = (state_d[i] == RUN);
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_count
        assign bus.count[g*WIDTH +: WIDTH] = cnt_q[g];
    end

    assign bus.running    = run_q;
    assign bus.expired    = exp_q;
    assign bus.wrap_pulse = wrap_q;
endmodule

// File: tb/tb_park_timer_bank.sv
// Drives three differently parameterised timer banks with shared stimulus and scoreboards them
// against a per-bay behavioural model.
module tb_park_timer_bank;
    localparam int CH = 4;
    localparam int W  = 10;
    localparam int ND = 3;

    localparam int P_MAX  [ND] = '{999, 999, 20};
    localparam int P_TO   [ND] = '{900, 900, 12};
    localparam int P_PS   [ND] = '{1, 1, 4};
    localparam int P_WRAP [ND] = '{1, 0, 1};

    localparam int S_IDLE   = 0;
    localparam int S_RUN    = 1;
    localparam int S_PAUSED = 2;

    typedef struct packed {
        logic [ND*CH*W-1:0] count;
        logic [ND*CH-1:0]   running;
        logic [ND*CH-1:0]   expired;
        logic [ND*CH-1:0]   wrapp;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    park_timer_bank_if #(.CH(CH), .WIDTH(W)) if_a ();
    park_timer_bank_if #(.CH(CH), .WIDTH(W)) if_b ();
    park_timer_bank_if #(.CH(CH), .WIDTH(W)) if_c ();

    park_timer_bank #(.CH(CH), .WIDTH(W), .MAX_COUNT(999), .TIMEOUT(900), .PRESCALE(1), .WRAP(1))
        dut_a (.clk(clk), .reset(reset), .bus(if_a));
    park_timer_bank #(.CH(CH), .WIDTH(W), .MAX_COUNT(999), .TIMEOUT(900), .PRESCALE(1), .WRAP(0))
        dut_b (.clk(clk), .reset(reset), .bus(if_b));
    park_timer_bank #(.CH(CH), .WIDTH(W), .MAX_COUNT(20), .TIMEOUT(12), .PRESCALE(4), .WRAP(1))
        dut_c (.clk(clk), .reset(reset), .bus(if_c));

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q [$];

    int m_st    [ND][CH];
    int m_cnt   [ND][CH];
    bit m_exp   [ND][CH];
    bit m_wrap  [ND][CH];
    int m_since [ND];

    task automatic model_step(input logic [CH-1:0] st, input logic [CH-1:0] sp,
                              input logic [CH-1:0] cl, input logic rs);
        exp_t e;
        e = '0;
        for (int d = 0; d < ND; d++) begin
            bit tick;
            tick = 1'b0;
            if (rs) begin
                m_since[d] = 0;
                for (int c = 0; c < CH; c++) begin
                    m_st[d][c] = S_IDLE; m_cnt[d][c] = 0; m_exp[d][c] = 0; m_wrap[d][c] = 0;
                end
            end else begin
                tick = (m_since[d] % P_PS[d]) == P_PS[d] - 1;
                m_since[d]++;
                for (int c = 0; c < CH; c++) begin
                    bit adv;
                    adv = 0;
                    m_wrap[d][c] = 0;
                    if (cl[c]) begin
                        m_st[d][c] = S_IDLE; m_cnt[d][c] = 0; m_exp[d][c] = 0;
                    end else if (st[c]) begin
                        if (m_st[d][c] == S_IDLE) begin
                            m_st[d][c] = S_RUN; m_cnt[d][c] = 0; m_exp[d][c] = 0;
                        end else if (m_st[d][c] == S_PAUSED) begin
                            m_st[d][c] = S_RUN;
                        end else begin
                            adv = tick && !sp[c];
                        end
                    end else if (sp[c]) begin
                        if (m_st[d][c] == S_RUN) m_st[d][c] = S_PAUSED;
                    end else begin
                        adv = tick && (m_st[d][c] == S_RUN);
                    end
                    if (adv) begin
                        if (m_cnt[d][c] == P_MAX[d]) begin
                            if (P_WRAP[d] != 0) begin
                                m_cnt[d][c] = 0;
                                m_wrap[d][c] = 1;
                                if (P_TO[d] == 0) m_exp[d][c] = 1;
                            end
                        end else begin
                            m_cnt[d][c]++;
                            if (m_cnt[d][c] == P_TO[d]) m_exp[d][c] = 1;
                        end
                    end
                end
            end
            for (int c = 0; c < CH; c++) begin
                e.count[(d*CH+c)*W +: W] = W'(m_cnt[d][c]);
                e.running[d*CH+c]        = (m_st[d][c] == S_RUN);
                e.expired[d*CH+c]        = m_exp[d][c];
                e.wrapp[d*CH+c]          = m_wrap[d][c];
            end
        end
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic [CH-1:0] st, input logic [CH-1:0] sp,
                         input logic [CH-1:0] cl, input logic rs);
        @(negedge clk);
        reset = rs;
        if_a.start = st; if_a.stop = sp; if_a.clear = cl;
        if_b.start = st; if_b.stop = sp; if_b.clear = cl;
        if_c.start = st; if_c.stop = sp; if_c.clear = cl;
        model_step(st, sp, cl, rs);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0, '0, '0, 1'b0);
    endtask

    task automatic check(input string name, input int d, input logic [63:0] act,
                         input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s dut%0d got %h expected %h at %0t", name, d, act, expv, $time);
        end
    endtask

    // Monitor: the DUT presents status every cycle, so each edge retires one expectation.
    initial begin
        exp_t e;
        logic [ND*CH*W-1:0] a_cnt;
        logic [ND*CH-1:0]   a_run, a_exp, a_wrp;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e     = sb_q.pop_front();
                a_cnt = {if_c.count, if_b.count, if_a.count};
                a_run = {if_c.running, if_b.running, if_a.running};
                a_exp = {if_c.expired, if_b.expired, if_a.expired};
                a_wrp = {if_c.wrap_pulse, if_b.wrap_pulse, if_a.wrap_pulse};
                for (int d = 0; d < ND; d++) begin
                    check("count", d, 64'(a_cnt[d*CH*W +: CH*W]), 64'(e.count[d*CH*W +: CH*W]));
                    check("running", d, 64'(a_run[d*CH +: CH]), 64'(e.running[d*CH +: CH]));
                    check("expired", d, 64'(a_exp[d*CH +: CH]), 64'(e.expired[d*CH +: CH]));
                    check("wrap_pulse", d, 64'(a_wrp[d*CH +: CH]), 64'(e.wrapp[d*CH +: CH]));
                end
            end
        end
    end

    initial begin
        logic [CH-1:0] st, sp, cl;
        reset = 1'b1;
        if_a.start = '0; if_a.stop = '0; if_a.clear = '0;
        if_b.start = '0; if_b.stop = '0; if_b.clear = '0;
        if_c.start = '0; if_c.stop = '0; if_c.clear = '0;

        // Reset with start held must leave every bay idle.
        repeat (3) drive('1, '0, '0, 1'b1);
        idle(2);

        // Single start pulse on bay 0, then free counting.
        drive(4'b0001, '0, '0, 1'b0);
        idle(10);

        // Bay 1 runs past timeout and MAX_COUNT, with a pause/resume near the end.
        drive(4'b0010, '0, '0, 1'b0);
        for (int i = 0; i < 1010; i++) begin
            if (i == 950)      drive('0, 4'b0010, '0, 1'b0);
            else if (i == 955) drive(4'b0010, '0, '0, 1'b0);
            else               drive('0, '0, '0, 1'b0);
        end

        // All bays running; clear+start+stop together on bay 3 mid-count.
        drive('1, '0, '0, 1'b0);
        for (int i = 0; i < 910; i++) begin
            if (i == 500) drive(4'b1000, 4'b1000, 4'b1000, 1'b0);
            else          drive('0, '0, '0, 1'b0);
        end

        // Reset while running/expired, start held through release.
        repeat (2) drive('1, '0, '0, 1'b1);
        drive('1, '0, '0, 1'b0);
        idle(5);

        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < CH; c++) begin
                st[c] = ($urandom_range(0, 15) == 0);
                sp[c] = ($urandom_range(0, 15) == 0);
                cl[c] = ($urandom_range(0, 39) == 0);
            end
            drive(st, sp, cl, $urandom_range(0, 499) == 0);
        end

        idle(3);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
